// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - dual-port RAM, registered read, byte enables, hardware clear sweep; optional RAM_WR_BYPASS_EN
module ram_dp_clr #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 9,
   parameter int BYTEWIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           we,
   input  logic [ADDRWIDTH-1:0]           wr_addr,
   input  logic [DATAWIDTH/BYTEWIDTH-1:0] wr_be,
   input  logic [DATAWIDTH-1:0]           wr_data,
   input  logic                           re,
   input  logic [ADDRWIDTH-1:0]           rd_addr,
   output logic [DATAWIDTH-1:0]           rd_data,
   output logic                           rd_valid,
   input  logic                           clr_req,
   output logic                           busy
);
   localparam int NBYTES = DATAWIDTH / BYTEWIDTH;
   localparam int DEPTH  = 1 << ADDRWIDTH;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t               state;
   logic [ADDRWIDTH-1:0] clr_addr;
   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [DATAWIDTH-1:0] rd_word;
   logic                 user_wr;

   // a user write lands only in IDLE and only when no clear is being requested
   assign user_wr = (state == IDLE) && !clr_req && we;

   // word presented to the read register; with bypass, written lanes win on an address hit
   always_comb begin
      rd_word = mem[rd_addr];
`ifdef RAM_WR_BYPASS_EN
      if (we && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) rd_word[i*BYTEWIDTH +: BYTEWIDTH] = wr_data[i*BYTEWIDTH +: BYTEWIDTH];
         end
      end
`endif
   end

   // array write port: the clear sweep owns it while in CLEAR, otherwise byte-lane user writes
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_addr] <= '0;
      end else if (user_wr) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) mem[wr_addr][i*BYTEWIDTH +: BYTEWIDTH] <= wr_data[i*BYTEWIDTH +: BYTEWIDTH];
         end
      end
   end

   // control FSM with registered busy and read outputs; clear request beats same-cycle reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
         busy     <= 1'b1;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            CLEAR: begin
               clr_addr <= clr_addr + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
               if (clr_addr == '1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (clr_req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
                  busy     <= 1'b1;
               end else if (re) begin
                  rd_data  <= rd_word;
                  rd_valid <= 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb/tb_ram_dp_clr.sv - self-checking bench for ram_dp_clr with a behavioural reference model
module tb_ram_dp_clr;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NB = DW / 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          we = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [NB-1:0] wr_be = '0;
   logic [DW-1:0] wr_data = '0;
   logic          re = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          clr_req = 1'b0;
   logic          busy;

   int compared = 0;
   int mismatched = 0;

   ram_dp_clr #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8)) dut (
      .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .re(re), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .clr_req(clr_req), .busy(busy)
   );

   always #5 clk = ~clk;

   // reference model: contents array, remaining clear cycles, expected read outputs
   logic [DW-1:0] m_mem [DEPTH];
   int            m_left = DEPTH;
   logic [DW-1:0] m_rd_data = '0;
   logic          m_rd_valid = 1'b0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [NB-1:0] be);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_left = DEPTH;
         m_rd_data = '0;
         m_rd_valid = 1'b0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         m_rd_valid = 1'b0;
      end else if (clr_req) begin
         // the array ends all-zero and nothing user-visible lands meanwhile
         m_left = DEPTH;
         m_rd_valid = 1'b0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end else begin
         if (re) begin
`ifdef RAM_WR_BYPASS_EN
            m_rd_data = (we && wr_addr == rd_addr) ? merge(m_mem[rd_addr], wr_data, wr_be) : m_mem[rd_addr];
`else
            m_rd_data = m_mem[rd_addr];
`endif
            m_rd_valid = 1'b1;
         end else begin
            m_rd_valid = 1'b0;
         end
         if (we) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      check("busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      check("rd_valid", {31'b0, rd_valid}, {31'b0, m_rd_valid});
      check("rd_data", rd_data, m_rd_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0; clr_req = 1'b0;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      we = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
      tick();
   endtask

   task automatic rd_chk(input string name, input int a, input logic [DW-1:0] exp);
      re = 1'b1; rd_addr = AW'(a);
      tick();
      check({name, "_valid"}, {31'b0, rd_valid}, 32'd1);
      check(name, rd_data, exp);
   endtask

   task automatic count_busy(input string name);
      int n;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check(name, n, 32'd16);
   endtask

   initial begin
      logic [DW-1:0] exp_v;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, busy}, 32'd1);
      check("reset_rd_data", rd_data, 32'd0);
      check("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
      reset = 1'b0;
      count_busy("sweep_len_after_reset");
      for (int a = 0; a < DEPTH; a++) rd_chk("zero_after_reset", a, 32'd0);

      // byte-lane merge
      wr(3, 32'hDEADBEEF, 4'b1111);
      wr(3, 32'h00005500, 4'b0010);
      rd_chk("byte_merge", 3, 32'hDEAD55EF);
      wr(3, 32'h12345678, 4'b0000);
      rd_chk("be_zero_noop", 3, 32'hDEAD55EF);

      // same-address read/write, full and partial lanes
      wr(5, 32'h22222222, 4'b1111);
      we = 1'b1; wr_addr = 4'd5; wr_data = 32'h11111111; wr_be = 4'b1111; re = 1'b1; rd_addr = 4'd5;
      tick();
`ifdef RAM_WR_BYPASS_EN
      exp_v = 32'h11111111;
`else
      exp_v = 32'h22222222;
`endif
      check("same_addr_full", rd_data, exp_v);
      wr(5, 32'h22222222, 4'b1111);
      we = 1'b1; wr_addr = 4'd5; wr_data = 32'h11111111; wr_be = 4'b0001; re = 1'b1; rd_addr = 4'd5;
      tick();
`ifdef RAM_WR_BYPASS_EN
      exp_v = 32'h22222211;
`else
      exp_v = 32'h22222222;
`endif
      check("same_addr_lane0", rd_data, exp_v);
      rd_chk("same_addr_after", 5, 32'h22222211);

      // clear request beats same-cycle write and read
      wr(7, 32'h0000AAAA, 4'b1111);
      clr_req = 1'b1; we = 1'b1; wr_addr = 4'd7; wr_data = 32'h00005555; wr_be = 4'b1111;
      re = 1'b1; rd_addr = 4'd7;
      tick();
      check("clr_no_rd_valid", {31'b0, rd_valid}, 32'd0);
      check("clr_busy", {31'b0, busy}, 32'd1);
      count_busy("sweep_len_clr_req");
      for (int a = 0; a < DEPTH; a++) rd_chk("zero_after_clr", a, 32'd0);

      // reset five cycles into a sweep
      wr(9, 32'hCAFEF00D, 4'b1111);
      rd_chk("pre_reset_read", 9, 32'hCAFEF00D);
      clr_req = 1'b1;
      tick();
      repeat (5) tick();
      reset = 1'b1;
      #1;
      check("midsweep_rst_busy", {31'b0, busy}, 32'd1);
      check("midsweep_rst_rd_data", rd_data, 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      count_busy("sweep_len_after_midreset");

      // back-to-back reads
      for (int a = 0; a < 4; a++) wr(a, 32'hA0B0C000 + 32'(a), 4'b1111);
      for (int a = 0; a < 4; a++) begin
         re = 1'b1; rd_addr = AW'(a);
         tick();
         if (a < 3) begin
            re = 1'b1; rd_addr = AW'(a + 1);
         end
         check("b2b_valid", {31'b0, rd_valid}, 32'd1);
         check("b2b_data", rd_data, 32'hA0B0C000 + 32'(a));
         if (a < 3) re = 1'b0;
      end
      tick();
      check("hold_valid", {31'b0, rd_valid}, 32'd0);
      check("hold_data", rd_data, 32'hA0B0C003);

      // random traffic, occasional clear requests, model compared every cycle
      for (int c = 0; c < 3000; c++) begin
         we = 1'($urandom_range(0, 1));
         re = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, DEPTH - 1));
         rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
         wr_be = NB'($urandom);
         wr_data = $urandom;
         clr_req = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
      end

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
